seg_display_arbiter: RTL and testbench

//  Time-slice scheduler sharing one 4-digit seven-segment display (two 2-digit values) among 3 requesters.

---
 rtl/seg_display_arbiter_if.sv | 22 ++
 rtl/seg_display_arbiter.sv | 138 +++++++++++++
 tb/tb_seg_display_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seg_display_arbiter_if.sv
// Request/display bundle shared by the requesters (master) and the display arbiter (slave).
// Request slices are packed {src2, src1, src0}, 5 bits each.
interface seg_display_arbiter_if;
  logic [2:0]  req;
  logic [14:0] req_data0;
  logic [14:0] req_data1;
  logic [2:0]  grant;
  logic [4:0]  disp_data0;
  logic [4:0]  disp_data1;
  logic        disp_valid;
  logic        scan_tick;

  modport master (
    output req, req_data0, req_data1,
    input  grant, disp_data0, disp_data1, disp_valid, scan_tick
  );

  modport slave (
    input  req, req_data0, req_data1,
    output grant, disp_data0, disp_data1, disp_valid, scan_tick
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin time-slice arbiter for a shared 4-digit seven-segment display, plus scan-rate tick.
// Define SEG_ARB_PRIORITY_EN to make source 0 urgent (preempts on req rise, regranted at expiry).
module seg_display_arbiter #(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int SCAN_DIV     = 100_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_display_arbiter_if.slave  bus
);

  localparam int DW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [2:0]      r_grant;
  logic [2:0]      w_grant_next;
  logic [1:0]      r_last;
  logic [1:0]      w_last_next;
  logic [DW-1:0]   r_dwell;
  logic [DW-1:0]   w_dwell_next;
  logic [SW-1:0]   r_scan_cnt;
  logic            r_scan_tick;
  logic [4:0]      r_disp0;
  logic [4:0]      r_disp1;
  logic            r_valid;
  logic            r_req0_d;
  logic            w_owner_req;
  logic            w_expire;
  logic            w_req0_rise;
  logic [4:0]      w_slice0 [3];
  logic [4:0]      w_slice1 [3];
  logic [4:0]      w_mux0;
  logic [4:0]      w_mux1;

  // First requester strictly after 'last' in 0->1->2->0 order, wrapping back to 'last' itself.
  function automatic logic [2:0] f_rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [2:0] pick;
    logic [2:0] s;
    pick = '0;
    for (int k = 3; k >= 1; k--) begin
      s = 3'(last) + 3'(k);
      if (s >= 3'd3) s = s - 3'd3;
      if (req[s[1:0]]) pick = 3'b001 << s[1:0];
    end
    return pick;
  endfunction

  function automatic logic [1:0] f_idx(input logic [2:0] onehot);
    case (onehot)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  assign w_owner_req = |(bus.req & r_grant);
  assign w_expire    = (r_dwell == DW'(DWELL_CYCLES - 1));
  assign w_req0_rise = bus.req[0] & ~r_req0_d;

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_dwell_next = r_dwell;
    case (r_state)
      S_IDLE: begin
        w_dwell_next = '0;
        w_grant_next = f_rr_pick(bus.req, r_last);
        if (|bus.req) w_state_next = S_HOLD;
      end
      default: begin
        w_dwell_next = r_dwell + 1'b1;
`ifdef SEG_ARB_PRIORITY_EN
        if (w_req0_rise && !r_grant[0]) begin
          w_grant_next = 3'b001;
          w_dwell_next = '0;
        end else if (w_owner_req && w_expire && r_grant[0]) begin
          w_dwell_next = '0;
        end else
`endif
        // Release wins over a coincident expiry, so the owner is masked out.
        if (!w_owner_req) begin
          w_grant_next = f_rr_pick(bus.req & ~r_grant, r_last);
          w_dwell_next = '0;
          if (w_grant_next == 3'b000) w_state_next = S_IDLE;
        end else if (w_expire) begin
          w_grant_next = f_rr_pick(bus.req, r_last);
          w_dwell_next = '0;
        end
      end
    endcase
    w_last_next = (|w_grant_next) ? f_idx(w_grant_next) : r_last;
  end

  // Data is muxed on the next grant so grant and value land on the same edge.
  for (genvar gi = 0; gi < 3; gi++) begin : g_slice
    assign w_slice0[gi] = bus.req_data0[gi*5 +: 5] & {5{w_grant_next[gi]}};
    assign w_slice1[gi] = bus.req_data1[gi*5 +: 5] & {5{w_grant_next[gi]}};
  end
  assign w_mux0 = w_slice0[0] | w_slice0[1] | w_slice0[2];
  assign w_mux1 = w_slice1[0] | w_slice1[1] | w_slice1[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_last      <= 2'd2;
      r_dwell     <= '0;
      r_disp0     <= '0;
      r_disp1     <= '0;
      r_valid     <= 1'b0;
      r_req0_d    <= 1'b0;
      r_scan_cnt  <= '0;
      r_scan_tick <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_last      <= w_last_next;
      r_dwell     <= w_dwell_next;
      r_disp0     <= w_mux0;
      r_disp1     <= w_mux1;
      r_valid     <= |w_grant_next;
      r_req0_d    <= bus.req[0];
      r_scan_cnt  <= (r_scan_cnt == SW'(SCAN_DIV - 1)) ? '0 : r_scan_cnt + 1'b1;
      r_scan_tick <= (r_scan_cnt == SW'(SCAN_DIV - 2));
    end
  end

  assign bus.grant      = r_grant;
  assign bus.disp_data0 = r_disp0;
  assign bus.disp_data1 = r_disp1;
  assign bus.disp_valid = r_valid;
  assign bus.scan_tick  = r_scan_tick;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed scoreboard bench for seg_display_arbiter (DWELL_CYCLES=8, SCAN_DIV=4).
// Expectations are queued per scenario and popped one per clock edge.
module tb_seg_display_arbiter;
  localparam int DWELL = 8;
  localparam int SDIV  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   n_edges  = 0;

  typedef struct {
    string      tag;
    logic [2:0] g;
    logic [4:0] d0;
    logic [4:0] d1;
  } exp_t;
  exp_t q[$];

  seg_display_arbiter_if bus_if ();

  seg_display_arbiter #(.DWELL_CYCLES(DWELL), .SCAN_DIV(SDIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int n, input logic [2:0] g,
                      input logic [4:0] d0, input logic [4:0] d1);
    exp_t e;
    e.tag = tag; e.g = g; e.d0 = d0; e.d1 = d1;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // One clock edge: scan-tick model check, then pop and compare one expectation.
  task automatic run_q();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk);
      if (!rst_n) n_edges = 0;
      else        n_edges++;
      #1;
      $display("[%0t] %s grant=%b d0=%0d d1=%0d valid=%b tick=%b", $time, e.tag,
               bus_if.grant, bus_if.disp_data0, bus_if.disp_data1, bus_if.disp_valid, bus_if.scan_tick);
      chk({e.tag, ".grant"}, 8'(bus_if.grant), 8'(e.g));
      chk({e.tag, ".d0"}, 8'(bus_if.disp_data0), 8'(e.d0));
      chk({e.tag, ".d1"}, 8'(bus_if.disp_data1), 8'(e.d1));
      chk({e.tag, ".valid"}, 8'(bus_if.disp_valid), 8'(e.g != 3'b000));
      chk({e.tag, ".scan_tick"}, 8'(bus_if.scan_tick), 8'((n_edges % SDIV) == SDIV - 1));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.req = 3'b000;
    bus_if.req_data0 = '0;
    bus_if.req_data1 = '0;

    // Reset held, then idle with scan ticks at edges 3, 7, 11 after release.
    push("reset", 5, 3'b000, 5'd0, 5'd0);
    run_q();
    rst_n = 1'b1;
    push("idle", 12, 3'b000, 5'd0, 5'd0);
    run_q();

    // All three request: rotation 0 -> 1 -> 2 -> 0 every 8 cycles.
    bus_if.req_data0 = {5'd7, 5'd25, 5'd12};
    bus_if.req_data1 = {5'd3, 5'd2, 5'd1};
    bus_if.req = 3'b111;
`ifdef SEG_ARB_PRIORITY_EN
    push("rr_prio", 26, 3'b001, 5'd12, 5'd1);
`else
    push("rr_src0", 8, 3'b001, 5'd12, 5'd1);
    push("rr_src1", 8, 3'b010, 5'd25, 5'd2);
    push("rr_src2", 8, 3'b100, 5'd7, 5'd3);
    push("rr_wrap", 2, 3'b001, 5'd12, 5'd1);
`endif
    run_q();

    // Source 1 alone: released owner hands over, then seamless regrants.
    bus_if.req_data1 = {5'd3, 5'd31, 5'd1};
    bus_if.req = 3'b010;
    push("solo_src1", 25, 3'b010, 5'd25, 5'd31);
    push("dwell_to_3", 3, 3'b010, 5'd25, 5'd31);
    run_q();

    // Owner drops at dwell 3 with 0 and 2 requesting: RR from 1 picks 2.
    bus_if.req = 3'b101;
    push("drop_src1", 1, 3'b100, 5'd7, 5'd3);
    run_q();
    bus_if.req_data0 = {5'd9, 5'd25, 5'd12};
    push("live_data", 1, 3'b100, 5'd9, 5'd3);
    run_q();
    bus_if.req = 3'b000;
    push("to_idle", 2, 3'b000, 5'd0, 5'd0);
    run_q();

    // Reset during HOLD at dwell 5, then source 0 wins first again.
    bus_if.req = 3'b111;
    push("hold_dw5", 6, 3'b001, 5'd12, 5'd1);
    run_q();
    rst_n = 1'b0;
    push("mid_reset", 1, 3'b000, 5'd0, 5'd0);
    run_q();
    rst_n = 1'b1;
    push("post_reset", 1, 3'b001, 5'd12, 5'd1);
    run_q();

    // Source 2 owns; req[0] rises at dwell 2.
    bus_if.req = 3'b100;
    push("src2_own", 3, 3'b100, 5'd9, 5'd3);
    run_q();
    bus_if.req = 3'b101;
`ifdef SEG_ARB_PRIORITY_EN
    push("preempt", 2, 3'b001, 5'd12, 5'd1);
`else
    push("no_preempt", 5, 3'b100, 5'd9, 5'd3);
    push("expiry_rr", 2, 3'b001, 5'd12, 5'd1);
`endif
    run_q();
    bus_if.req = 3'b000;
    push("final_idle", 1, 3'b000, 5'd0, 5'd0);
    run_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
